// File: rtl/regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_pkg : shared types, defaults and bus helper for regfile_mp |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package regfile_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  localparam int c_DATA_W_DEFAULT = 32;
  localparam int c_ADDR_W_DEFAULT = 5;
  localparam int c_MAX_BUS_W      = 256;
  localparam int c_MAX_FIELD_W    = 64;

  // Extract field p of width w from a packed bus; callers cast to the real width.
  function automatic logic [c_MAX_FIELD_W-1:0] unpack_port(
    input logic [c_MAX_BUS_W-1:0] bus,
    input int unsigned            p,
    input int unsigned            w
  );
    logic [c_MAX_BUS_W-1:0] sh;
    logic [c_MAX_BUS_W-1:0] mask;
    sh   = bus >> (p * w);
    mask = ~({c_MAX_BUS_W{1'b1}} << w);
    return c_MAX_FIELD_W'(sh & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clr_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_clr_seq : clear-sweep sequencer, one entry zeroed per clk |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] c_LAST = '1;

  clr_state_t        r_state;
  clr_state_t        w_next;
  logic [ADDR_W-1:0] r_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLR_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CLR_IDLE && clr_req) begin
        r_idx <= '0;
      end else if (r_state == CLR_SWEEP && r_idx != c_LAST) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    sweep_we = 1'b0;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (r_state)
      CLR_IDLE: begin
        if (clr_req) w_next = CLR_SWEEP;
      end
      CLR_SWEEP: begin
        clr_busy = 1'b1;
        sweep_we = 1'b1;
        if (r_idx == c_LAST) w_next = CLR_DONE;
      end
      CLR_DONE: begin
        clr_done = 1'b1;
        w_next   = CLR_IDLE;
      end
      default: w_next = CLR_IDLE;
    endcase
  end

  assign sweep_addr = r_idx;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_mp : multi-port register file with clear sweep            |
// | Optional write forwarding: define REGFILE_BYPASS_EN               |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W_DEFAULT,
  parameter int ADDR_W   = c_ADDR_W_DEFAULT,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] wa,
  input  logic [NWRITE*DATA_W-1:0] wd,
  input  logic [NREAD*ADDR_W-1:0]  ra,
  output logic [NREAD*DATA_W-1:0]  rd,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int c_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W-1:0] w_wa  [NWRITE];
  logic [DATA_W-1:0] w_wd  [NWRITE];
  logic [ADDR_W-1:0] w_ra  [NREAD];
  logic              w_sweep_we;
  logic [ADDR_W-1:0] w_sweep_addr;

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_req    (clr_req),
    .sweep_we   (w_sweep_we),
    .sweep_addr (w_sweep_addr),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
  );

  for (genvar p = 0; p < NWRITE; p++) begin : g_wport
    assign w_wa[p] = ADDR_W'(unpack_port(c_MAX_BUS_W'(wa), p, ADDR_W));
    assign w_wd[p] = DATA_W'(unpack_port(c_MAX_BUS_W'(wd), p, DATA_W));
  end

  // Sweep clear goes first so a same-cycle user write overrides it; later
  // ports override earlier ones on address collisions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_sweep_we) r_mem[w_sweep_addr] <= '0;
      for (int p = 0; p < NWRITE; p++) begin
        if (we[p] && !((ZERO_REG != 0) && (w_wa[p] == '0))) begin
          r_mem[w_wa[p]] <= w_wd[p];
        end
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rport
    logic [DATA_W-1:0] w_rdata;
    assign w_ra[i] = ADDR_W'(unpack_port(c_MAX_BUS_W'(ra), i, ADDR_W));

    always_comb begin
      w_rdata = r_mem[w_ra[i]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWRITE; p++) begin
        if (we[p] && (w_wa[p] == w_ra[i])) w_rdata = w_wd[p];
      end
`endif
      if ((ZERO_REG != 0) && (w_ra[i] == '0)) w_rdata = '0;
    end

    assign rd[i*DATA_W +: DATA_W] = w_rdata;
  end

endmodule
`default_nettype wire
